id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly downstream of the 32x32 register file.
//  Captures decoded operands, immediate, register indices and control each cycle.
//  Supports stall, flush/bubble and same-cycle WB write-through bypass.
//  Refreshes held operands while stalled so the EX stage never consumes stale data.
// PARAMETERS
//  XLEN    32  datapath width (operands, imm, pc)
//  CTRL_W  12  width of packed EX/MEM/WB control bundle
// PORTS
//  clk      in   1       rising-edge clock
//  rst      in   1       asynchronous, active-low reset
//  stall    in   1       hold all ex_* outputs this cycle
//  flush    in   1       load a bubble this cycle
//  id_valid in   1       ID holds a real instruction
//  id_pc    in   XLEN    PC of the ID instruction
//  id_rs1   in   5       source index 1 (also drives RF A1)
//  id_rs2   in   5       source index 2 (also drives RF A2)
//  id_rd    in   5       destination index
//  id_rd1   in   XLEN    RF read data 1
//  id_rd2   in   XLEN    RF read data 2
//  id_imm   in   XLEN    sign-extended immediate
//  id_ctrl  in   CTRL_W  control bundle from decoder
//  wb_we    in   1       WB write enable (same signal as RF WE3)
//  wb_rd    in   5       WB destination (same as RF A3)
//  wb_wd    in   XLEN    WB write data (same as RF WD3)
//  ex_valid out  1       EX slot holds a real instruction
//  ex_pc, ex_rd1, ex_rd2, ex_imm  out XLEN   registered copies
//  ex_rs1, ex_rs2, ex_rd          out 5      registered copies
//  ex_ctrl                        out CTRL_W registered copy
// BEHAVIOUR
//  - Reset (rst=0, async): every output 0; ex_valid=0, ex_ctrl=NOP (all zeros).
//  - Latency 1 cycle: ID values visible on ex_* after the next rising edge.
//  - Priority per edge: reset > flush > stall > load.
//  - flush=1: ex_valid=0, ex_ctrl=0, ex_rd=0, all other outputs 0; flush wins over stall.
//  - stall=1, flush=0: all outputs hold, except the operand refresh below.
//  - load: ex_valid<=id_valid; if id_valid=0, ex_ctrl<=0 and ex_rd<=0 (bubble).
//  - Operand select at load (per operand n):
//      rsn==0 -> 0; else bypass hit (wb_we && wb_rd==rsn && wb_rd!=0) -> wb_wd; else id_rdn.
//  - Stall refresh: ex_valid && stall && !flush && wb_we && wb_rd!=0 && wb_rd==ex_rsn
//    -> ex_rdn<=wb_wd. ex_rs1 and ex_rs2 are refreshed independently; both update if equal.
//  - rs1==rs2 with a bypass hit: both operands take wb_wd.
//  - Reset asserted mid-stall or mid-flush: outputs clear immediately; no state survives.
//  - No arithmetic is performed; all fields are passed without width change.
// CONFIGURATION
//  - Macro IDEX_BYPASS_EN.
//  - Defined: write-through bypass at load and stall refresh, as above.
//  - Undefined: operands taken straight from id_rd1/id_rd2 (rs==0 still forces 0);
//    no refresh during stall; wb_* inputs are unused. Downstream forwarding must then
//    cover the WB distance.
// STRUCTURE
//  - pipe_pkg: CTRL_W, control-field bit positions, CTRL_NOP, REG_ZERO=5'd0.
//  - Sub-module operand_bypass: combinational rs/wb compare and select, instantiated
//    once per operand and reused for both load and refresh.
// TESTING
//  1. rst=0 mid-run -> all ex_* = 0 asynchronously, before the next clk edge.
//  2. id_rs1=5, id_rd1=0x11, wb_we=1, wb_rd=5, wb_wd=0xAA -> ex_rd1=0xAA next cycle
//     (0x11 when IDEX_BYPASS_EN is undefined).
//  3. id_rs2=0, id_rd2=0xFFFF, wb_we=1, wb_rd=0 -> ex_rd2=0.
//  4. Load rs1=7, then stall 3 cycles with WB writing x7=0x55 in cycle 2
//     -> ex_rd1=0x55 from cycle 3; all other fields unchanged.
//  5. stall=1 and flush=1 together -> ex_valid=0, ex_ctrl=0, ex_rd=0.
//  6. id_valid=0 with id_ctrl=0xFFF, id_rd=9 -> ex_valid=0, ex_ctrl=0, ex_rd=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle width, field positions and the NOP encoding.
package pipe_pkg;

    localparam int CTRL_W = 12;

    // Bit positions inside the packed EX/MEM/WB control bundle.
    localparam int CTRL_ALU_OP_LSB   = 0;
    localparam int CTRL_ALU_SRC      = 4;
    localparam int CTRL_BRANCH       = 5;
    localparam int CTRL_JUMP         = 6;
    localparam int CTRL_MEM_RD       = 7;
    localparam int CTRL_MEM_WR       = 8;
    localparam int CTRL_MEM_SIZE_LSB = 9;
    localparam int CTRL_REG_WR       = 11;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    localparam logic [4:0]        REG_ZERO = 5'd0;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic [3:0] alu_op,
        input logic       alu_src,
        input logic       branch,
        input logic       jump,
        input logic       mem_rd,
        input logic       mem_wr,
        input logic [1:0] mem_size,
        input logic       reg_wr
    );
        logic [CTRL_W-1:0] c;
        c = CTRL_NOP;
        c[CTRL_ALU_OP_LSB +: 4]   = alu_op;
        c[CTRL_ALU_SRC]           = alu_src;
        c[CTRL_BRANCH]            = branch;
        c[CTRL_JUMP]              = jump;
        c[CTRL_MEM_RD]            = mem_rd;
        c[CTRL_MEM_WR]            = mem_wr;
        c[CTRL_MEM_SIZE_LSB +: 2] = mem_size;
        c[CTRL_REG_WR]            = reg_wr;
        return c;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-operand source select: x0 forcing and WB write-through compare.
// Bypass compare exists only when IDEX_BYPASS_EN is defined.
module operand_bypass
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rd_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    output logic            hit,
    output logic [XLEN-1:0] value
);

`ifdef IDEX_BYPASS_EN
    // A write to x0 never forwards, so hit already implies rs != 0.
    assign hit = wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_rd};
    assign hit       = 1'b0;
`endif

    assign value = (rs == REG_ZERO) ? '0 :
                   hit              ? wb_wd :
                                      rd_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, stall and optional WB write-through bypass
// (enabled by IDEX_BYPASS_EN, which also enables operand refresh while stalled).
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wd,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic [4:0]      byp_rs  [2];
    logic [XLEN-1:0] byp_rd  [2];
    logic            byp_hit [2];
    logic [XLEN-1:0] byp_val [2];

    // While stalled the compare looks at the held indices, so one instance serves load and refresh.
    assign byp_rs[0] = stall ? ex_rs1 : id_rs1;
    assign byp_rs[1] = stall ? ex_rs2 : id_rs2;
    assign byp_rd[0] = id_rd1;
    assign byp_rd[1] = id_rd2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            operand_bypass #(.XLEN(XLEN)) u_bypass (
                .rs      (byp_rs[gi]),
                .rd_data (byp_rd[gi]),
                .wb_we   (wb_we),
                .wb_rd   (wb_rd),
                .wb_wd   (wb_wd),
                .hit     (byp_hit[gi]),
                .value   (byp_val[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs1   <= pipe_pkg::REG_ZERO;
            ex_rs2   <= pipe_pkg::REG_ZERO;
            ex_rd    <= pipe_pkg::REG_ZERO;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs1   <= pipe_pkg::REG_ZERO;
            ex_rs2   <= pipe_pkg::REG_ZERO;
            ex_rd    <= pipe_pkg::REG_ZERO;
            ex_ctrl  <= '0;
        end else if (stall) begin
            if (ex_valid && byp_hit[0]) begin
                ex_rd1 <= byp_val[0];
            end
            if (ex_valid && byp_hit[1]) begin
                ex_rd2 <= byp_val[1];
            end
        end else begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_rd1   <= byp_val[0];
            ex_rd2   <= byp_val[1];
            ex_imm   <= id_imm;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_valid ? id_rd   : pipe_pkg::REG_ZERO;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus async-reset and stall-refresh sequences.
module tb_id_ex_stage;
    import pipe_pkg::*;

`ifdef IDEX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        stall, flush, valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic [11:0] ctrl;
        logic        we;
        logic [4:0]  wbrd;
        logic [31:0] wbwd;
    } in_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic [11:0] ctrl;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, id_valid, wb_we;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm, wb_wd;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [11:0] id_ctrl;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input out_t e);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
        chk({tag, ".pc"},    ex_pc,         e.pc);
        chk({tag, ".rs1"},   32'(ex_rs1),   32'(e.rs1));
        chk({tag, ".rs2"},   32'(ex_rs2),   32'(e.rs2));
        chk({tag, ".rd"},    32'(ex_rd),    32'(e.rd));
        chk({tag, ".rd1"},   ex_rd1,        e.rd1);
        chk({tag, ".rd2"},   ex_rd2,        e.rd2);
        chk({tag, ".imm"},   ex_imm,        e.imm);
        chk({tag, ".ctrl"},  32'(ex_ctrl),  32'(e.ctrl));
    endtask

    task automatic drive(input in_t v);
        stall = v.stall;  flush = v.flush;  id_valid = v.valid;
        id_pc = v.pc;     id_rs1 = v.rs1;   id_rs2 = v.rs2;  id_rd = v.rd;
        id_rd1 = v.rd1;   id_rd2 = v.rd2;   id_imm = v.imm;  id_ctrl = v.ctrl;
        wb_we = v.we;     wb_rd = v.wbrd;   wb_wd = v.wbwd;
    endtask

    vec_t tbl[11];
    out_t zero_o, held_o;
    in_t  idle_i, ld_i;

    initial begin
        zero_o = '{1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 12'h0};
        idle_i = '{1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 12'h0, 1'b0, 5'd0, 32'h0};

        // v0: plain load
        tbl[0].i = '{0, 0, 1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 32'hFFFF_FFF0,
                     pack_ctrl(4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1), 0, 5'd0, 32'h0};
        tbl[0].e = '{1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 32'hFFFF_FFF0, 12'hC5A};
        // v1: WB write-through on rs1
        tbl[1].i = '{0, 0, 1, 32'h104, 5'd5, 5'd6, 5'd4, 32'h11, 32'h66, 32'h10, 12'h001, 1, 5'd5, 32'hAA};
        tbl[1].e = '{1, 32'h104, 5'd5, 5'd6, 5'd4, BYP ? 32'hAA : 32'h11, 32'h66, 32'h10, 12'h001};
        // v2: rs2 = x0 forces zero even with a WB to x0
        tbl[2].i = '{0, 0, 1, 32'h108, 5'd8, 5'd0, 5'd7, 32'h88, 32'hFFFF, 32'h20, 12'h002, 1, 5'd0, 32'hBB};
        tbl[2].e = '{1, 32'h108, 5'd8, 5'd0, 5'd7, 32'h88, 32'h0, 32'h20, 12'h002};
        // v3: rs1 == rs2 with a bypass hit
        tbl[3].i = '{0, 0, 1, 32'h10C, 5'd9, 5'd9, 5'd1, 32'h91, 32'h92, 32'h30, 12'h003, 1, 5'd9, 32'hCC};
        tbl[3].e = '{1, 32'h10C, 5'd9, 5'd9, 5'd1, BYP ? 32'hCC : 32'h91, BYP ? 32'hCC : 32'h92, 32'h30, 12'h003};
        // v4: matching wb_rd but wb_we low
        tbl[4].i = '{0, 0, 1, 32'h110, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hB0, 32'h4, 12'h123, 0, 5'd10, 32'hDD};
        tbl[4].e = '{1, 32'h110, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hB0, 32'h4, 12'h123};
        // v5: stall holds, rs2 refreshed from WB
        tbl[5].i = '{1, 0, 1, 32'h999, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 12'h777, 1, 5'd11, 32'hEE};
        tbl[5].e = '{1, 32'h110, 5'd10, 5'd11, 5'd12, 32'hA0, BYP ? 32'hEE : 32'hB0, 32'h4, 12'h123};
        // v6: stall and flush together -> flush wins
        tbl[6].i = '{1, 1, 1, 32'h114, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 12'h456, 1, 5'd10, 32'h99};
        tbl[6].e = zero_o;
        // v7: bubble from ID
        tbl[7].i = '{0, 0, 0, 32'h200, 5'd1, 5'd2, 5'd9, 32'h5, 32'h6, 32'h8, 12'hFFF, 0, 5'd0, 32'h0};
        tbl[7].e = '{0, 32'h200, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 32'h8, 12'h000};
        // v8: stall with ex_valid=0 -> no refresh
        tbl[8].i = '{1, 0, 1, 32'h204, 5'd7, 5'd7, 5'd7, 32'h9, 32'h9, 32'h9, 12'h111, 1, 5'd1, 32'h77};
        tbl[8].e = '{0, 32'h200, 5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 32'h8, 12'h000};
        // v9: extreme values, bypass on rs2
        tbl[9].i = '{0, 0, 1, 32'h300, 5'd31, 5'd30, 5'd31, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8000_0000,
                     12'h800, 1, 5'd30, 32'h1234_5678};
        tbl[9].e = '{1, 32'h300, 5'd31, 5'd30, 5'd31, 32'hDEAD_BEEF, BYP ? 32'h1234_5678 : 32'hCAFE_F00D,
                     32'h8000_0000, 12'h800};
        // v10: flush alone
        tbl[10].i = '{0, 1, 1, 32'h304, 5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 32'h1, 12'h001, 0, 5'd0, 32'h0};
        tbl[10].e = zero_o;

        rst = 1'b0;
        drive(idle_i);
        #12;
        chk_all("reset", zero_o);
        $display("[TB] reset: outputs checked while rst low");
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].i);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", k), tbl[k].e);
            $display("[TB] vec %0d: stall=%0b flush=%0b valid=%0b rd1=%08h rd2=%08h ctrl=%03h",
                     k, tbl[k].i.stall, tbl[k].i.flush, tbl[k].i.valid, ex_rd1, ex_rd2, ex_ctrl);
        end

        // Asynchronous reset mid-stall: outputs clear before the next edge.
        drive(tbl[0].i);
        @(posedge clk);
        #1;
        chk_all("preload", tbl[0].e);
        stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", zero_o);
        $display("[TB] async reset mid-stall: valid=%0b pc=%08h", ex_valid, ex_pc);
        @(posedge clk);
        #1;
        chk_all("rst_hold", zero_o);
        @(negedge clk);
        rst = 1'b1;

        // Load rs1=7, then stall three cycles with WB writing x7 in the second.
        ld_i = '{0, 0, 1, 32'h400, 5'd7, 5'd3, 5'd6, 32'h70, 32'h30, 32'h44, 12'h0F0, 0, 5'd0, 32'h0};
        held_o = '{1, 32'h400, 5'd7, 5'd3, 5'd6, 32'h70, 32'h30, 32'h44, 12'h0F0};
        drive(ld_i);
        @(posedge clk);
        #1;
        chk_all("s4_load", held_o);
        $display("[TB] stall seq load: rd1=%08h", ex_rd1);
        for (int c = 1; c <= 3; c++) begin
            drive('{1, 0, 1, 32'h500 + 32'(c), 5'd2, 5'd2, 5'd2, 32'hBAD, 32'hBAD, 32'hBAD, 12'hBAD,
                    c == 2, c == 2 ? 5'd7 : 5'd0, c == 2 ? 32'h55 : 32'h0});
            @(posedge clk);
            #1;
            if (c >= 2 && BYP) held_o.rd1 = 32'h55;
            chk_all($sformatf("s4_stall%0d", c), held_o);
            $display("[TB] stall seq cycle %0d: rd1=%08h rd2=%08h", c, ex_rd1, ex_rd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
